als_spi_sampler: RTL

- SPI master for the Pmod ALS light sensor (ADC081S021 on the JA header); 12 MHz board clock.
- Repeatedly runs 16-bit read frames and publishes the raw frame as `value[15:0]`, with the 8-bit light level in `value[12:5]`.
- Sits directly upstream of the top-level level-bar logic, which consumes `value[12:9]`.
- Also provides a one-cycle update strobe and a frame-format error flag for debug LEDs.

---
 rtl/als_spi_sampler.sv | 136 +++++++++++++
 1 files changed

// File: rtl/als_spi_sampler.sv
// rtl/als_spi_sampler.sv - SPI master that repeatedly reads the Pmod ALS ADC (ADC081S021)
module als_spi_sampler #(
  parameter int SCK_HALF_PERIOD = 3,
  parameter int CS_HIGH_CYCLES  = 24
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  output logic        cs,
  output logic        sck,
  input  logic        sdo,
  output logic [15:0] value,
  output logic [7:0]  light,
  output logic        value_valid,
  output logic        frame_error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [7:0]  HALF_LAST = 8'(SCK_HALF_PERIOD - 1);
  localparam logic [15:0] GAP_MAX   = 16'(CS_HIGH_CYCLES);
  localparam logic [4:0]  BITS      = 5'd16;

  state_t      state_q, state_d;
  logic [7:0]  half_q, half_d;
  logic [4:0]  bit_q, bit_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] shift_q, shift_d;
  logic        cs_q, cs_d;
  logic        sck_q, sck_d;
  logic [15:0] value_q, value_d;
  logic [7:0]  light_q, light_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;

  // Next-state logic: gap timing in IDLE, SCK generation and sampling in FRAME, publish in DONE
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shift_d = shift_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    value_d = value_q;
    light_d = light_q;
    valid_d = 1'b0;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        cs_d  = 1'b1;
        sck_d = 1'b1;
        if (gap_q < GAP_MAX) begin
          gap_d = gap_q + 16'd1;
        end else if (enable) begin
          cs_d    = 1'b0;
          half_d  = 8'd0;
          bit_d   = 5'd0;
          state_d = ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (half_q == HALF_LAST) begin
          half_d = 8'd0;
          if (bit_q == BITS) begin
            // one extra half-period after the last rise before releasing cs
            cs_d    = 1'b1;
            state_d = ST_DONE;
          end else if (sck_q) begin
            sck_d = 1'b0;
          end else begin
            // ADC launched this bit on the preceding fall, so it has settled by now
            sck_d   = 1'b1;
            shift_d = {shift_q[14:0], sdo};
            bit_d   = bit_q + 5'd1;
          end
        end else begin
          half_d = half_q + 8'd1;
        end
      end
      ST_DONE: begin
        value_d = shift_q;
        light_d = shift_q[12:5];
        valid_d = 1'b1;
        // leading zeros and trailing zeros must be zero; bit 0 is the tristate slot
        error_d = (|shift_q[15:13]) | (|shift_q[4:1]);
        gap_d   = 16'd1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      half_q  <= 8'd0;
      bit_q   <= 5'd0;
      gap_q   <= 16'd0;
      shift_q <= 16'd0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b1;
      value_q <= 16'd0;
      light_q <= 8'd0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      value_q <= value_d;
      light_q <= light_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign cs          = cs_q;
  assign sck         = sck_q;
  assign value       = value_q;
  assign light       = light_q;
  assign value_valid = valid_q;
  assign frame_error = error_q;

endmodule
